// File: rtl/trap_sequencer.sv
// trap_sequencer: sequences exceptions, machine interrupts and MRET around the M-mode CSR file.
// Ports: clk/reset_n (async active-low); exc_*, irq_*, mret_valid are event sources;
// current_pc, mstatus_*, mie_in, mtvec_in, mepc_in are current CSR/pipeline state; pipe_idle ends DRAIN.
// Outputs: event_ack, hold_fetch, busy, CSR write strobes + data, redirect_valid/redirect_pc/flush,
// priv (current privilege), drain_timeout (sticky).
module trap_sequencer #(
  parameter logic [1:0] RESET_PRIV  = 2'b11,
  parameter bit         VECTORED_EN = 1'b1,
  parameter int         DRAIN_MAX   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        exc_valid,
  input  logic [4:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic        irq_ext,
  input  logic        irq_sw,
  input  logic        irq_timer,
  input  logic        mret_valid,
  input  logic [31:0] current_pc,
  input  logic        mstatus_mie,
  input  logic        mstatus_mpie,
  input  logic [1:0]  mstatus_mpp,
  input  logic [31:0] mie_in,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  input  logic        pipe_idle,
  output logic        event_ack,
  output logic        hold_fetch,
  output logic        busy,
  output logic        csr_trap_we,
  output logic        csr_mret_we,
  output logic [31:0] mepc_wdata,
  output logic [31:0] mcause_wdata,
  output logic        mstatus_mie_wdata,
  output logic        mstatus_mpie_wdata,
  output logic [1:0]  mstatus_mpp_wdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [1:0]  priv,
  output logic        drain_timeout
);
  localparam int CW = $clog2(DRAIN_MAX + 1);
  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_irq, is_mret;
  logic [4:0]    cause;
  logic [31:2]   epc;
  logic          int_ext, int_sw, int_tmr, int_req, any_ev;
  logic [4:0]    int_code;
  logic [31:0]   base, target;
  logic          unused;
  assign int_ext  = irq_ext & mie_in[11];
  assign int_sw   = irq_sw & mie_in[3];
  assign int_tmr  = irq_timer & mie_in[7];
  assign int_req  = mstatus_mie & (int_ext | int_sw | int_tmr);
  assign int_code = int_ext ? 5'd11 : int_sw ? 5'd3 : 5'd7;
  assign any_ev   = exc_valid | int_req | mret_valid;
  // state reads IDLE while reset is held, so gate the ack explicitly
  assign event_ack  = reset_n & (state == IDLE) & any_ev;
  assign busy       = state != IDLE;
  assign hold_fetch = busy;
  assign base   = {mtvec_in[31:2], 2'b00};
  assign target = is_mret ? mepc_in
                : (is_irq && VECTORED_EN && mtvec_in[1:0] == 2'b01) ? base + {25'b0, cause, 2'b00}
                : base;
  assign unused = ^{exc_pc[1:0], current_pc[1:0], mie_in[31:12], mie_in[10:8], mie_in[6:4], mie_in[2:0]};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      cnt                <= '0;
      is_irq             <= 1'b0;
      is_mret            <= 1'b0;
      cause              <= '0;
      epc                <= '0;
      csr_trap_we        <= 1'b0;
      csr_mret_we        <= 1'b0;
      mepc_wdata         <= '0;
      mcause_wdata       <= '0;
      mstatus_mie_wdata  <= 1'b0;
      mstatus_mpie_wdata <= 1'b0;
      mstatus_mpp_wdata  <= 2'b00;
      redirect_valid     <= 1'b0;
      redirect_pc        <= '0;
      flush              <= 1'b0;
      priv               <= RESET_PRIV;
      drain_timeout      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_ev) begin
          state   <= DRAIN;
          cnt     <= CW'(1);
          is_irq  <= !exc_valid && int_req;
          is_mret <= !exc_valid && !int_req;
          if (exc_valid || int_req) begin
            cause <= exc_valid ? exc_cause : int_code;
            epc   <= exc_valid ? exc_pc[31:2] : current_pc[31:2];
          end
        end
        // cnt counts DRAIN cycles including the current one
        DRAIN: if (pipe_idle || cnt == CW'(DRAIN_MAX)) begin
          state              <= COMMIT;
          drain_timeout      <= drain_timeout | !pipe_idle;
          csr_trap_we        <= !is_mret;
          csr_mret_we        <= is_mret;
          mstatus_mie_wdata  <= is_mret ? mstatus_mpie : 1'b0;
          mstatus_mpie_wdata <= is_mret ? 1'b1 : mstatus_mie;
          mstatus_mpp_wdata  <= is_mret ? 2'b00 : priv;
          if (!is_mret) begin
            mepc_wdata   <= {epc, 2'b00};
            mcause_wdata <= {is_irq, 26'b0, cause};
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
        COMMIT: begin
          state          <= REDIRECT;
          csr_trap_we    <= 1'b0;
          csr_mret_we    <= 1'b0;
          redirect_valid <= 1'b1;
          flush          <= 1'b1;
          redirect_pc    <= target;
          priv           <= is_mret ? mstatus_mpp : 2'b11;
        end
        REDIRECT: begin
          state          <= IDLE;
          redirect_valid <= 1'b0;
          flush          <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
